spi_reg_responder: RTL and testbench

//  SPI responder with a 4 x 8-bit register file, clocked entirely by the system clock.

---
 rtl/spi_reg_responder.sv | 156 +++++++++++++++
 tb/tb_spi_reg_responder.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/spi_reg_responder.sv
// spi_reg_responder: oversampled SPI responder with a 4 x 8-bit register file
module spi_reg_responder #(
    parameter logic [7:0] RST_VAL     = 8'h00,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk_40k,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
    output logic [7:0] reg0_out,
    output logic [7:0] reg1_out,
    output logic [7:0] reg2_out,
    output logic [7:0] reg3_out,
    output logic       wr_pulse,
    output logic       rd_pulse,
    output logic       frame_err,
    output logic       addr_err
);
    typedef enum logic [1:0] {IDLE, CMD, DATA, S_END} state_t;
    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sclk_prev_q, cs_prev_q;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;
    state_t                 state_q, state_d;
    logic [4:0]             cnt_q, cnt_d, cnt_inc;
    logic [7:0]             rx_q, rx_d, rx_next;
    logic [7:0]             tx_q, tx_d;
    logic                   rw_q, rw_d;
    logic [6:0]             addr_q, addr_d;
    logic                   miso_q, miso_d;
    logic                   wr_q, wr_d, rd_q, rd_d, fe_q, fe_d, ae_q, ae_d;
    logic                   good, in_range;
    logic [7:0]             regs_q [4];
    logic [7:0]             regs_d [4];

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;
    assign rx_next   = {rx_q[6:0], mosi_s};
    assign cnt_inc   = cnt_q + 5'd1;
    assign good      = cnt_q == 5'd16;
    assign in_range  = ~|addr_q[6:2];

    assign miso      = miso_q;
    assign wr_pulse  = wr_q;
    assign rd_pulse  = rd_q;
    assign frame_err = fe_q;
    assign addr_err  = ae_q;
    assign reg0_out  = regs_q[0];
    assign reg1_out  = regs_q[1];
    assign reg2_out  = regs_q[2];
    assign reg3_out  = regs_q[3];

    // Synchronizers and edge-detect history; cs_n idles high so reset release never looks like a frame start
    always_ff @(posedge clk_40k or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
        end
    end

    // Frame state, shift registers, register file and strobes
    always_ff @(posedge clk_40k or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rx_q    <= '0;
            tx_q    <= '0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            miso_q  <= 1'b0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            fe_q    <= 1'b0;
            ae_q    <= 1'b0;
            regs_q  <= '{default: RST_VAL};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rx_q    <= rx_d;
            tx_q    <= tx_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            miso_q  <= miso_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            fe_q    <= fe_d;
            ae_q    <= ae_d;
            regs_q  <= regs_d;
        end
    end

    // Next state: cs_n rise outranks any SCLK edge; evaluation is registered so strobes and commits land together
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rx_d    = rx_q;
        tx_d    = tx_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        miso_d  = miso_q;
        wr_d    = 1'b0;
        rd_d    = 1'b0;
        fe_d    = 1'b0;
        ae_d    = 1'b0;
        regs_d  = regs_q;
        if (state_q == IDLE) begin
            miso_d = 1'b0;
            if (cs_fall) begin
                state_d = CMD;
                cnt_d   = '0;
                rx_d    = '0;
                tx_d    = '0;
            end
        end else if (cs_rise) begin
            state_d = IDLE;
            miso_d  = 1'b0;
            fe_d    = !good;
            ae_d    = good && !in_range;
            wr_d    = good && !rw_q && in_range;
            rd_d    = good && rw_q && in_range;
            if (good && !rw_q && in_range) regs_d[addr_q[1:0]] = rx_q;
        end else begin
            if (sclk_fall) begin
                cnt_d = (cnt_q == 5'd17) ? cnt_q : cnt_inc;
                if (state_q != S_END) rx_d = rx_next;
                if (state_q == CMD && cnt_inc == 5'd8) begin
                    rw_d    = rx_next[7];
                    addr_d  = rx_next[6:0];
                    tx_d    = (rx_next[7] && ~|rx_next[6:2]) ? regs_q[rx_next[1:0]] : 8'h00;
                    state_d = DATA;
                end
                if (state_q == DATA && cnt_inc == 5'd16) state_d = S_END;
            end
            if (sclk_rise && state_q == DATA) begin
                miso_d = tx_q[7];
                tx_d   = {tx_q[6:0], 1'b0};
            end
        end
    end
endmodule

// File: tb/tb_spi_reg_responder.sv
// tb_spi_reg_responder: directed frames with a strobe scoreboard and register model
module tb_spi_reg_responder;
    localparam logic [7:0] RV = 8'h3C;
    localparam logic [3:0] E_WR = 4'b1000, E_RD = 4'b0100, E_FE = 4'b0010, E_AE = 4'b0001;

    logic       clk_40k = 1'b0;
    logic       rst_n = 1'b0, sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
    logic       miso, wr_pulse, rd_pulse, frame_err, addr_err;
    logic [7:0] reg0_out, reg1_out, reg2_out, reg3_out;
    logic [7:0] r_obs [4];
    logic [7:0] m [4];
    logic [3:0] exp_q [$];
    logic [7:0] rb;
    int         n_cmp = 0, n_mis = 0;

    spi_reg_responder #(.RST_VAL(RV), .SYNC_STAGES(2)) dut (
        .clk_40k(clk_40k), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .reg0_out(reg0_out), .reg1_out(reg1_out), .reg2_out(reg2_out),
        .reg3_out(reg3_out), .wr_pulse(wr_pulse), .rd_pulse(rd_pulse),
        .frame_err(frame_err), .addr_err(addr_err)
    );

    assign r_obs[0] = reg0_out;
    assign r_obs[1] = reg1_out;
    assign r_obs[2] = reg2_out;
    assign r_obs[3] = reg3_out;

    always #5 clk_40k = ~clk_40k;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_regs(input string tag);
        @(negedge clk_40k);
        for (int i = 0; i < 4; i++) chk($sformatf("%s_reg%0d", tag, i), 32'(r_obs[i]), 32'(m[i]));
    endtask

    // Every strobe cycle consumes one expected event, so a stretched strobe shows up as an extra pop
    always @(negedge clk_40k) begin
        if (rst_n && (wr_pulse || rd_pulse || frame_err || addr_err)) begin
            if (exp_q.size() == 0) chk("strobe_unexpected", 32'({wr_pulse, rd_pulse, frame_err, addr_err}), 32'h0);
            else chk("strobe", 32'({wr_pulse, rd_pulse, frame_err, addr_err}), 32'(exp_q.pop_front()));
        end
    end

    task automatic frame(input logic [31:0] w, input int n, input int abort_at, input int gap,
                         output logic [7:0] rbyte);
        rbyte = 8'h00;
        @(posedge clk_40k);
        cs_n = 1'b0;
        repeat (8) @(posedge clk_40k);
        for (int i = 0; i < n; i++) begin
            sclk = 1'b1;
            mosi = w[31-i];
            repeat (8) @(posedge clk_40k);
            if (i == abort_at) begin
                rst_n = 1'b0;
                @(negedge clk_40k);
                chk("rst_mid_miso", 32'(miso), 32'h0);
                chk("rst_mid_reg2", 32'(reg2_out), 32'(RV));
                sclk = 1'b0;
                cs_n = 1'b1;
                mosi = 1'b0;
                repeat (4) @(posedge clk_40k);
                rst_n = 1'b1;
                repeat (gap) @(posedge clk_40k);
                return;
            end
            @(negedge clk_40k);
            if (i >= 8 && i < 16) rbyte = {rbyte[6:0], miso};
            sclk = 1'b0;
            repeat (8) @(posedge clk_40k);
        end
        cs_n = 1'b1;
        mosi = 1'b0;
        repeat (gap) @(posedge clk_40k);
    endtask

    function automatic logic [31:0] wr_w(input logic [6:0] a, input logic [7:0] d);
        return {1'b0, a, d, 16'h0};
    endfunction

    function automatic logic [31:0] rd_w(input logic [6:0] a);
        return {1'b1, a, 8'h00, 16'h0};
    endfunction

    initial begin
        m = '{default: RV};
        repeat (5) @(posedge clk_40k);
        @(negedge clk_40k);
        chk("reset_miso", 32'(miso), 32'h0);
        chk("reset_strobes", 32'({wr_pulse, rd_pulse, frame_err, addr_err}), 32'h0);
        chk_regs("reset");
        rst_n = 1'b1;
        repeat (5) @(posedge clk_40k);

        exp_q.push_back(E_WR);
        frame(wr_w(7'd1, 8'h5A), 16, -1, 16, rb);
        m[1] = 8'h5A;
        chk_regs("t1");

        exp_q.push_back(E_WR);
        frame(wr_w(7'd3, 8'hC3), 16, -1, 16, rb);
        m[3] = 8'hC3;
        exp_q.push_back(E_RD);
        frame(rd_w(7'd3), 16, -1, 16, rb);
        chk("t2_read_miso", 32'(rb), 32'hC3);
        chk_regs("t2");
        exp_q.push_back(E_RD);
        frame(rd_w(7'd1), 16, -1, 16, rb);
        chk("t2_read1_miso", 32'(rb), 32'h5A);

        exp_q.push_back(E_AE);
        frame(wr_w(7'h05, 8'hFF), 16, -1, 16, rb);
        chk_regs("t3_wr");
        exp_q.push_back(E_AE);
        frame(rd_w(7'h05), 16, -1, 16, rb);
        chk("t3_read_miso", 32'(rb), 32'h00);
        chk_regs("t3_rd");

        exp_q.push_back(E_FE);
        frame(wr_w(7'd0, 8'hEE), 10, -1, 16, rb);
        chk_regs("t4_short");
        exp_q.push_back(E_FE);
        frame(wr_w(7'd0, 8'hEE), 17, -1, 16, rb);
        chk_regs("t4_long");

        exp_q.push_back(E_WR);
        frame(wr_w(7'd2, 8'h44), 16, -1, 16, rb);
        m[2] = 8'h44;
        chk_regs("t5_pre");
        frame(wr_w(7'd2, 8'h77), 16, 12, 16, rb);
        m = '{default: RV};
        chk_regs("t5_rst");
        exp_q.push_back(E_WR);
        frame(wr_w(7'd2, 8'h99), 16, -1, 16, rb);
        m[2] = 8'h99;
        chk_regs("t5_after");

        exp_q.push_back(E_WR);
        frame(wr_w(7'd0, 8'h11), 16, -1, 32, rb);
        exp_q.push_back(E_WR);
        frame(wr_w(7'd1, 8'h22), 16, -1, 16, rb);
        m[0] = 8'h11;
        m[1] = 8'h22;
        chk_regs("t6");

        repeat (10) @(posedge clk_40k);
        @(negedge clk_40k);
        chk("strobes_outstanding", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
